// File: rtl/enemy_pkg.sv
// Shared types and helpers for the enemy squad mover: direction encoding,
// scan FSM states and free-vector utilities.
package enemy_pkg;

    // Direction encoding; reverse of a direction is obtained by flipping bit 1.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Opposite direction: UP<->DOWN, RIGHT<->LEFT.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

    // Number of free directions in a {up,right,down,left} vector.
    function automatic logic [2:0] free_count(input logic [3:0] f);
        return {2'b00, f[3]} + {2'b00, f[2]} + {2'b00, f[1]} + {2'b00, f[0]};
    endfunction

    // Is direction d open in free vector f (bit 3 = up ... bit 0 = left)?
    function automatic logic dir_free(input logic [3:0] f, input dir_t d);
        logic r;
        case (d)
            DIR_UP:    r = f[3];
            DIR_RIGHT: r = f[2];
            DIR_DOWN:  r = f[1];
            default:   r = f[0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/enemy_dir_decide.sv
// Combinational direction choice for one enemy: corridor following, the
// no-reverse rule, and chase/flee steering at junctions.
module enemy_dir_decide
    import enemy_pkg::*;
#(
    parameter int COORD_W     = 11,
    parameter int BLOCK_SHIFT = 5
) (
    input  logic [3:0]                free_vec,
    input  dir_t                      cur_dir,
    input  logic signed [COORD_W-1:0] enemy_x,
    input  logic signed [COORD_W-1:0] enemy_y,
    input  logic signed [COORD_W-1:0] player_x,
    input  logic signed [COORD_W-1:0] player_y,
    input  logic                      chase_mode,
    output dir_t                      new_dir,
    output logic                      move
);

    localparam int BW = COORD_W - BLOCK_SHIFT;

    // Block coordinates are the upper bits of the pixel coordinate, compared unsigned.
    logic [BW-1:0] ex_b, ey_b, px_b, py_b;
    logic [BW-1:0] dx, dy;
    logic          unused_bits;

    assign ex_b = enemy_x[COORD_W-1:BLOCK_SHIFT];
    assign ey_b = enemy_y[COORD_W-1:BLOCK_SHIFT];
    assign px_b = player_x[COORD_W-1:BLOCK_SHIFT];
    assign py_b = player_y[COORD_W-1:BLOCK_SHIFT];
    assign dx   = (ex_b > px_b) ? (ex_b - px_b) : (px_b - ex_b);
    assign dy   = (ey_b > py_b) ? (ey_b - py_b) : (py_b - ey_b);

    assign unused_bits = ^{enemy_x[BLOCK_SHIFT-1:0], enemy_y[BLOCK_SHIFT-1:0],
                           player_x[BLOCK_SHIFT-1:0], player_y[BLOCK_SHIFT-1:0]};

    dir_t       rev, tgt_x, tgt_y, prim, sec, any_free, first_nonrev, d_k;
    logic [2:0] cnt;

    // Pick the next direction; reversal only happens when it is the sole exit.
    always_comb begin
        rev          = reverse_dir(cur_dir);
        cnt          = free_count(free_vec);
        new_dir      = cur_dir;
        move         = 1'b0;
        any_free     = cur_dir;
        first_nonrev = cur_dir;
        d_k          = DIR_UP;

        // Descending scan so the lowest-numbered (UP first) candidate wins.
        for (int k = 3; k >= 0; k--) begin
            d_k = dir_t'(k[1:0]);
            if (dir_free(free_vec, d_k)) begin
                any_free = d_k;
                if (d_k != rev) first_nonrev = d_k;
            end
        end

        // Equal block coordinate resolves to RIGHT / DOWN in either mode.
        if (px_b == ex_b)                     tgt_x = DIR_RIGHT;
        else if ((px_b > ex_b) == chase_mode) tgt_x = DIR_RIGHT;
        else                                  tgt_x = DIR_LEFT;

        if (py_b == ey_b)                     tgt_y = DIR_DOWN;
        else if ((py_b > ey_b) == chase_mode) tgt_y = DIR_DOWN;
        else                                  tgt_y = DIR_UP;

        prim = (dx >= dy) ? tgt_x : tgt_y;
        sec  = (dx >= dy) ? tgt_y : tgt_x;

        case (cnt)
            3'd0: begin
                new_dir = cur_dir;
                move    = 1'b0;
            end
            3'd1: begin
                new_dir = any_free;
                move    = 1'b1;
            end
            3'd2: begin
                move = 1'b1;
                if (dir_free(free_vec, cur_dir)) begin
                    new_dir = cur_dir;
                end else if (cur_dir == DIR_UP || cur_dir == DIR_DOWN) begin
                    if (dir_free(free_vec, DIR_RIGHT))     new_dir = DIR_RIGHT;
                    else if (dir_free(free_vec, DIR_LEFT)) new_dir = DIR_LEFT;
                    else                                   new_dir = any_free;
                end else begin
                    if (dir_free(free_vec, DIR_UP))        new_dir = DIR_UP;
                    else if (dir_free(free_vec, DIR_DOWN)) new_dir = DIR_DOWN;
                    else                                   new_dir = any_free;
                end
            end
            default: begin
                move = 1'b1;
                if (dir_free(free_vec, prim) && prim != rev)     new_dir = prim;
                else if (dir_free(free_vec, sec) && sec != rev)  new_dir = sec;
                else                                             new_dir = first_nonrev;
            end
        endcase
    end

endmodule

// File: rtl/enemy_squad_mover.sv
// Moves a squad of maze enemies once per frame, visiting one enemy per cycle
// through a single shared direction-decision unit, with staggered respawn.
module enemy_squad_mover
    import enemy_pkg::*;
#(
    parameter int N_ENEMIES      = 4,
    parameter int COORD_W        = 11,
    parameter int FRAC_BITS      = 6,
    parameter int SPEED          = 128,
    parameter int BLOCK_SHIFT    = 5,
    parameter int SPAWN_X        = 504,
    parameter int SPAWN_Y        = 344,
    parameter int RESPAWN_FRAMES = 256,
    parameter int SPAWN_STAGGER  = 64
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic [4*N_ENEMIES-1:0]         free_dir_flat,
    input  logic signed [COORD_W-1:0]      player_top_leftX,
    input  logic signed [COORD_W-1:0]      player_top_leftY,
    input  logic                           chase_mode,
    input  logic [N_ENEMIES-1:0]           kill_vec,
    input  logic                           player_died,
    output logic [COORD_W*N_ENEMIES-1:0]   topLeftX_flat,
    output logic [COORD_W*N_ENEMIES-1:0]   topLeftY_flat,
    output logic [2*N_ENEMIES-1:0]         dir_flat,
    output logic [N_ENEMIES-1:0]           alive_vec,
    output logic                           busy
);

    localparam int POS_W = COORD_W + FRAC_BITS;
    localparam int IDX_W = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
    localparam int CNT_W = 16;

    localparam logic signed [POS_W-1:0] SPAWN_X_FP = POS_W'(SPAWN_X * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] SPAWN_Y_FP = POS_W'(SPAWN_Y * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] STEP       = POS_W'(SPEED);
    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(N_ENEMIES - 1);

    scan_state_t             state;
    logic [IDX_W-1:0]        idx;

    logic signed [POS_W-1:0] pos_x [N_ENEMIES];
    logic signed [POS_W-1:0] pos_y [N_ENEMIES];
    dir_t                    dir_r [N_ENEMIES];
    logic [CNT_W-1:0]        dead_cnt [N_ENEMIES];
    logic [N_ENEMIES-1:0]    alive_r;

    logic [3:0]              cur_free;
    logic signed [COORD_W-1:0] cur_x_px, cur_y_px;
    dir_t                    dec_dir;
    logic                    dec_move;

    // Operands of the enemy currently being visited.
    assign cur_free = free_dir_flat[4*idx +: 4];
    assign cur_x_px = pos_x[idx][POS_W-1:FRAC_BITS];
    assign cur_y_px = pos_y[idx][POS_W-1:FRAC_BITS];

    enemy_dir_decide #(
        .COORD_W     (COORD_W),
        .BLOCK_SHIFT (BLOCK_SHIFT)
    ) u_decide (
        .free_vec   (cur_free),
        .cur_dir    (dir_r[idx]),
        .enemy_x    (cur_x_px),
        .enemy_y    (cur_y_px),
        .player_x   (player_top_leftX),
        .player_y   (player_top_leftY),
        .chase_mode (chase_mode),
        .new_dir    (dec_dir),
        .move       (dec_move)
    );

    // Scan FSM: one frame pulse walks the index across all enemies; pulses while busy are dropped.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startOfFrame) begin
                        state <= SCAN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == LAST_IDX) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-enemy state: kills win over the scan slot, alive enemies move, dead ones count to respawn.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < N_ENEMIES; i++) begin
                pos_x[i]    <= SPAWN_X_FP;
                pos_y[i]    <= SPAWN_Y_FP;
                dir_r[i]    <= DIR_LEFT;
                dead_cnt[i] <= '0;
            end
            alive_r <= '1;
        end else begin
            for (int i = 0; i < N_ENEMIES; i++) begin
                if (kill_vec[i] || player_died) begin
                    alive_r[i]  <= 1'b0;
                    dead_cnt[i] <= '0;
                end else if (state == SCAN && idx == IDX_W'(i)) begin
                    if (alive_r[i]) begin
                        dir_r[i] <= dec_dir;
                        if (dec_move) begin
                            case (dec_dir)
                                DIR_UP:    pos_y[i] <= pos_y[i] - STEP;
                                DIR_RIGHT: pos_x[i] <= pos_x[i] + STEP;
                                DIR_DOWN:  pos_y[i] <= pos_y[i] + STEP;
                                default:   pos_x[i] <= pos_x[i] - STEP;
                            endcase
                        end
                    end else if (dead_cnt[i] + 1'b1 == CNT_W'(RESPAWN_FRAMES + i * SPAWN_STAGGER)) begin
                        pos_x[i]    <= SPAWN_X_FP;
                        pos_y[i]    <= SPAWN_Y_FP;
                        dir_r[i]    <= DIR_LEFT;
                        alive_r[i]  <= 1'b1;
                        dead_cnt[i] <= '0;
                    end else begin
                        dead_cnt[i] <= dead_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Pixel outputs are the integer part of the fixed-point positions.
    for (genvar g = 0; g < N_ENEMIES; g++) begin : g_out
        assign topLeftX_flat[COORD_W*g +: COORD_W] = pos_x[g][POS_W-1:FRAC_BITS];
        assign topLeftY_flat[COORD_W*g +: COORD_W] = pos_y[g][POS_W-1:FRAC_BITS];
        assign dir_flat[2*g +: 2]                  = dir_r[g];
    end

    assign alive_vec = alive_r;

endmodule

// File: tb/tb_enemy_squad_mover.sv
// Directed bench for enemy_squad_mover: a vector table of single-frame steering
// cases on enemy 0, plus sequences for framing, kills, respawn and reset.
module tb_enemy_squad_mover;

    localparam int N  = 4;
    localparam int CW = 11;

    logic              clk;
    logic              resetN;
    logic              startOfFrame;
    logic [4*N-1:0]    free_dir_flat;
    logic signed [CW-1:0] player_top_leftX;
    logic signed [CW-1:0] player_top_leftY;
    logic              chase_mode;
    logic [N-1:0]      kill_vec;
    logic              player_died;
    logic [CW*N-1:0]   topLeftX_flat;
    logic [CW*N-1:0]   topLeftY_flat;
    logic [2*N-1:0]    dir_flat;
    logic [N-1:0]      alive_vec;
    logic              busy;

    int checks = 0;
    int errors = 0;

    enemy_squad_mover dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .free_dir_flat    (free_dir_flat),
        .player_top_leftX (player_top_leftX),
        .player_top_leftY (player_top_leftY),
        .chase_mode       (chase_mode),
        .kill_vec         (kill_vec),
        .player_died      (player_died),
        .topLeftX_flat    (topLeftX_flat),
        .topLeftY_flat    (topLeftY_flat),
        .dir_flat         (dir_flat),
        .alive_vec        (alive_vec),
        .busy             (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        kill_vec      = '0;
        player_died   = 1'b0;
        free_dir_flat = '0;
        chase_mode    = 1'b1;
        player_top_leftX = 11'sd504;
        player_top_leftY = 11'sd344;
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (N + 1) tick();
    endtask

    function automatic int getx(int i);
        logic signed [CW-1:0] v;
        v = topLeftX_flat[CW*i +: CW];
        return int'(v);
    endfunction

    function automatic int gety(int i);
        logic signed [CW-1:0] v;
        v = topLeftY_flat[CW*i +: CW];
        return int'(v);
    endfunction

    function automatic int getd(int i);
        logic [1:0] v;
        v = dir_flat[2*i +: 2];
        return int'(v);
    endfunction

    // Scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] pre_free;
        logic [3:0] free;
        logic       chase;
        int         px;
        int         py;
        int         exp_dir;
        int         exp_x;
        int         exp_y;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // dir codes: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT; spawn block (15,10)
        vecs[0]  = '{4'b0000, 4'b1111, 1'b1, 600, 376, 2, 504, 346}; // junction chase, right is reverse -> down
        vecs[1]  = '{4'b0000, 4'b1111, 1'b0, 600, 376, 3, 502, 344}; // junction flee -> left
        vecs[2]  = '{4'b0000, 4'b0100, 1'b1, 504, 344, 1, 506, 344}; // single exit reverses
        vecs[3]  = '{4'b0000, 4'b0000, 1'b1, 504, 344, 3, 504, 344}; // boxed in: hold
        vecs[4]  = '{4'b0000, 4'b0101, 1'b1, 504, 344, 3, 502, 344}; // corridor keeps dir
        vecs[5]  = '{4'b0000, 4'b1010, 1'b1, 504, 344, 0, 504, 342}; // corner from left prefers up
        vecs[6]  = '{4'b0000, 4'b0110, 1'b1, 504, 344, 2, 504, 346}; // corner from left, up closed -> down
        vecs[7]  = '{4'b1000, 4'b0101, 1'b1, 504, 344, 1, 506, 342}; // from up prefers right
        vecs[8]  = '{4'b1000, 4'b0011, 1'b1, 504, 344, 3, 502, 342}; // from up, right closed -> left
        vecs[9]  = '{4'b0000, 4'b1111, 1'b1, 536, 472, 2, 504, 346}; // Y primary chase -> down
        vecs[10] = '{4'b0000, 4'b1111, 1'b0, 536, 472, 0, 504, 342}; // Y primary flee -> up
        vecs[11] = '{4'b0000, 4'b1111, 1'b0, 504, 344, 2, 504, 346}; // equal blocks: right rev -> down
        vecs[12] = '{4'b0000, 4'b0111, 1'b1, 600, 248, 2, 504, 346}; // both targets blocked -> fallback down
        vecs[13] = '{4'b1000, 4'b1101, 1'b1, 600, 376, 1, 506, 342}; // from up, X primary right
        vecs[14] = '{4'b1000, 4'b1111, 1'b1, 504, 504, 1, 506, 342}; // down is reverse, equal X -> right
    end

    initial begin
        // Reset state
        do_reset();
        for (int i = 0; i < N; i++) begin
            check($sformatf("reset_x%0d", i), getx(i), 504);
            check($sformatf("reset_y%0d", i), gety(i), 344);
            check($sformatf("reset_dir%0d", i), getd(i), 3);
        end
        check("reset_alive", alive_vec, 4'hF);
        check("reset_busy", busy, 0);

        // Busy window and straight-line travel
        free_dir_flat = 16'h1111;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        for (int k = 0; k < N; k++) begin
            check($sformatf("busy_slot%0d", k), busy, 1);
            tick();
        end
        check("busy_end", busy, 0);
        tick();
        repeat (5) frame();
        for (int i = 0; i < N; i++) begin
            check($sformatf("six_frames_x%0d", i), getx(i), 492);
            check($sformatf("six_frames_y%0d", i), gety(i), 344);
        end

        // Vector table on enemy 0
        for (int v = 0; v < 15; v++) begin
            do_reset();
            chase_mode       = vecs[v].chase;
            player_top_leftX = 11'(vecs[v].px);
            player_top_leftY = 11'(vecs[v].py);
            free_dir_flat    = {12'h000, vecs[v].pre_free};
            frame();
            free_dir_flat    = {12'h000, vecs[v].free};
            frame();
            check($sformatf("vec%0d_dir", v), getd(0), vecs[v].exp_dir);
            check($sformatf("vec%0d_x", v), getx(0), vecs[v].exp_x);
            check($sformatf("vec%0d_y", v), gety(0), vecs[v].exp_y);
        end

        // Second start pulse during a scan is ignored
        do_reset();
        free_dir_flat = 16'h1111;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (4) tick();
        check("ignored_sof_busy", busy, 0);
        check("ignored_sof_x0", getx(0), 502);
        check("ignored_sof_x3", getx(3), 502);

        // Kill in enemy 1's scan slot, then staggered respawn
        do_reset();
        free_dir_flat = 16'h1111;
        frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        kill_vec = 4'b0010;
        tick();
        kill_vec = 4'b0000;
        repeat (3) tick();
        check("kill_x0", getx(0), 500);
        check("kill_x1_frozen", getx(1), 502);
        check("kill_x2", getx(2), 500);
        check("kill_alive", alive_vec, 4'b1101);
        free_dir_flat = 16'h0010;
        repeat (319) frame();
        check("dead_319_alive", alive_vec, 4'b1101);
        check("dead_319_x1", getx(1), 502);
        frame();
        check("respawn_alive", alive_vec, 4'hF);
        check("respawn_x1", getx(1), 504);
        check("respawn_y1", gety(1), 344);
        check("respawn_dir1", getd(1), 3);

        // Player death and staggered return of the whole squad
        do_reset();
        player_died = 1'b1;
        tick();
        player_died = 1'b0;
        check("died_alive", alive_vec, 4'h0);
        for (int f = 1; f <= 448; f++) begin
            frame();
            if (f == 255) check("died_f255", alive_vec, 4'b0000);
            if (f == 256) check("died_f256", alive_vec, 4'b0001);
            if (f == 319) check("died_f319", alive_vec, 4'b0001);
            if (f == 320) check("died_f320", alive_vec, 4'b0011);
            if (f == 383) check("died_f383", alive_vec, 4'b0011);
            if (f == 384) check("died_f384", alive_vec, 4'b0111);
            if (f == 447) check("died_f447", alive_vec, 4'b0111);
            if (f == 448) check("died_f448", alive_vec, 4'b1111);
        end

        // Reset in the middle of a scan
        do_reset();
        free_dir_flat = 16'h1111;
        frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
        check("midscan_moved_x0", getx(0), 500);
        check("midscan_busy", busy, 1);
        resetN = 1'b0;
        tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("midreset_x%0d", i), getx(i), 504);
            check($sformatf("midreset_dir%0d", i), getd(i), 3);
        end
        check("midreset_busy", busy, 0);
        check("midreset_alive", alive_vec, 4'hF);
        resetN = 1'b1;
        repeat (3) tick();
        check("after_reset_busy", busy, 0);
        check("after_reset_x3", getx(3), 504);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
